// File: rtl/serial_frame_rx_pkg.sv
// rtl/serial_frame_rx_pkg.sv - shared types and constants for the serial frame receiver
// Purpose: receiver FSM state encoding and parity-mode constants.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Values accepted by the PARITY_EN parameter of serial_frame_rx.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - synchronous FIFO buffering received bytes
// Purpose: first-in-first-out store for received bytes.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and data
//   pop           read request (ignored while empty)
//   rdata         head entry, zero while empty
//   full, empty   occupancy flags
//   count         number of stored entries (DEPTH+1 bits)
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DEPTH:0]   count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a push into a full FIFO
  // alongside a pop is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (DEPTH + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver with output FIFO
// Purpose: deserialise start/data/parity/stop frames into bytes.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   sin, bit_en   serial line (LSB first, idles high) and bit qualifier
//   dataout,valid head of output FIFO and its valid flag
//   ready         consumer accept; transfer when valid & ready
//   frame_err     one-cycle pulse on a zero stop bit
//   parity_err    one-cycle pulse on parity mismatch
//   overflow      sticky: good byte dropped on a full FIFO
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dataout,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overflow
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic             acc_q, acc_d;
  logic             par_ok_q, par_ok_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overflow_q, overflow_d;
  logic             push_s;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_DEPTH:0] fifo_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; bit_en=0 freezes the FSM.
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        IDLE:    if (!sin) state_d = DATA;
        DATA:    if (cnt_q == LAST_BIT)
                   state_d = (PARITY_EN == PARITY_EVEN) ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs of the STOP decision; a zero stop bit outranks a parity miss.
  always_comb begin
    push_s       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (bit_en && state_q == STOP) begin
      if (!sin)                                         frame_err_d  = 1'b1;
      else if (par_ok_q || PARITY_EN == PARITY_NONE)    push_s       = 1'b1;
      else                                              parity_err_d = 1'b1;
    end
  end

  // Bit counter, shift register and running parity of the data bits.
  always_comb begin
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    par_ok_d = par_ok_q;
    if (bit_en) begin
      case (state_q)
        IDLE: if (!sin) begin
          cnt_d = '0;
          acc_d = 1'b0;
        end
        DATA: begin
          shreg_d = {sin, shreg_q[DATA_W-1:1]};
          acc_d   = acc_q ^ sin;
          cnt_d   = cnt_q + CW'(1);
        end
        PARITY:  par_ok_d = ~(acc_q ^ sin);
        default: ;
      endcase
    end
  end

  assign overflow_d = overflow_q | (push_s & fifo_full & ~fifo_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      acc_q        <= 1'b0;
      par_ok_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      acc_q        <= acc_d;
      par_ok_q     <= par_ok_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_pop = ready & (fifo_count != '0);

  rx_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (shreg_q),
    .pop   (fifo_pop),
    .rdata (dataout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid      = ~fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic       bit_en = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] dataout;
  logic       valid, frame_err, parity_err, overflow;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  serial_frame_rx #(
    .DATA_W(8),
    .PARITY_EN(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .bit_en     (bit_en),
    .dataout    (dataout),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sin    = b;
    bit_en = 1'b1;
  endtask

  task automatic stall_cycle();
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'($urandom_range(0, 1));
  endtask

  // Drives start, 8 data bits, parity and stop; returns with the stop bit on the line.
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input bit stall, input bit rdy_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (stall && i < 4) stall_cycle();
    end
    drive_bit(par_bit);
    drive_bit(stop_bit);
    if (rdy_stop) ready = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    sin    = 1'b1;
    bit_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1; bit_en = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++;
    if (dataout !== 8'h00) begin bad++; $display("FAIL reset_dataout: got %h want 00", dataout); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++;
    if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_good();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    settle();
    if (valid !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", valid); end
    total++;
    if (dataout !== exp_q[0]) begin bad++; $display("FAIL good_data: got %h want %h", dataout, exp_q[0]); end
    total++;
    if (frame_err !== 1'b0 || parity_err !== 1'b0) begin
      bad++; $display("FAIL good_errs: got %b%b want 00", frame_err, parity_err);
    end
    total++;
    ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    ready = 1'b0;
    if (valid !== 1'b0) begin bad++; $display("FAIL good_drained: got %b want 0", valid); end
    total++;
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, ^8'h3C, 1'b0, 0, 0);
    settle();
    if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL ferr_valid: got %b want 0", valid); end
    total++;
    if (parity_err !== 1'b0) begin bad++; $display("FAIL ferr_no_perr: got %b want 0", parity_err); end
    total++;
    @(negedge clk);
    if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_width: got %b want 0", frame_err); end
    total++;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1, 0, 0);
    settle();
    if (valid !== 1'b1 || dataout !== exp_q[0]) begin
      bad++; $display("FAIL ferr_next: got v=%b %h want v=1 %h", valid, dataout, exp_q[0]);
    end
    total++;
    ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_parity_err();
    send_frame(8'h07, 1'b0, 1'b1, 0, 0);
    settle();
    if (parity_err !== 1'b1) begin bad++; $display("FAIL perr_pulse: got %b want 1", parity_err); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL perr_no_ferr: got %b want 0", frame_err); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL perr_valid: got %b want 0", valid); end
    total++;
    if (dut.u_fifo.count !== 5'd0) begin bad++; $display("FAIL perr_count: got %0d want 0", dut.u_fifo.count); end
    total++;
    @(negedge clk);
    if (parity_err !== 1'b0) begin bad++; $display("FAIL perr_width: got %b want 0", parity_err); end
    total++;
  endtask

  task automatic test_stall();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, ^8'h5A, 1'b1, 1, 0);
    settle();
    if (valid !== 1'b1 || dataout !== exp_q[0]) begin
      bad++; $display("FAIL stall_data: got v=%b %h want v=1 %h", valid, dataout, exp_q[0]);
    end
    total++;
    ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; sin = 1'b0;
    @(negedge clk);
    rst = 1'b0; sin = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (frame_err !== 1'b0 || parity_err !== 1'b0 || valid !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet: got f=%b p=%b v=%b want 000", frame_err, parity_err, valid);
      end
      total++;
      @(negedge clk);
    end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, ^8'hFF, 1'b1, 0, 0);
    settle();
    if (valid !== 1'b1 || dataout !== exp_q[0]) begin
      bad++; $display("FAIL rstmid_next: got v=%b %h want v=1 %h", valid, dataout, exp_q[0]);
    end
    total++;
    ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      exp_b = 8'h10 + 8'(b);
      if (b < 4) exp_q.push_back(exp_b);
      send_frame(exp_b, ^exp_b, 1'b1, 0, 0);
    end
    settle();
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    total++;
    if (dut.u_fifo.count !== 5'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", dut.u_fifo.count); end
    total++;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = exp_q.pop_front();
      if (valid !== 1'b1 || dataout !== exp_b) begin
        bad++; $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", k, valid, dataout, exp_b);
      end
      total++;
      @(negedge clk);
    end
    ready = 1'b0;
    if (valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", valid); end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    total++;
  endtask

  task automatic test_full_boundary();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_b = 8'h20 + 8'(b);
      exp_q.push_back(exp_b);
      send_frame(exp_b, ^exp_b, 1'b1, 0, 0);
    end
    exp_q.push_back(8'h24);
    send_frame(8'h24, ^8'h24, 1'b1, 0, 1);
    exp_b = exp_q.pop_front();
    if (dataout !== exp_b) begin bad++; $display("FAIL full_head: got %h want %h", dataout, exp_b); end
    total++;
    settle();
    ready = 1'b0;
    if (dut.u_fifo.count !== 5'd4) begin bad++; $display("FAIL full_count: got %0d want 4", dut.u_fifo.count); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
    total++;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = exp_q.pop_front();
      if (valid !== 1'b1 || dataout !== exp_b) begin
        bad++; $display("FAIL full_drain%0d: got v=%b %h want v=1 %h", k, valid, dataout, exp_b);
      end
      total++;
      @(negedge clk);
    end
    ready = 1'b0;
    if (valid !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", valid); end
    total++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_frame_err();
    test_parity_err();
    test_stall();
    test_reset_midframe();
    test_overflow();
    test_full_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
